reg_writeback_port: RTL and testbench
=====================================

// Module: reg_writeback_port
// PURPOSE
// - Write-side driver for the 16x16 register group: buffers pipeline writeback
//   requests in a small FIFO and drives the group's write, address and data_in.
// - Turns each request into a clean SETUP / STROBE / HOLD sequence, because the
//   group captures data on the rising edge of its write input.
// - Forwards pending (not yet committed) values to the two read ports that
//   output_AB selects, so the decode stage sees the newest value.
// PARAMETERS
// - DEPTH   4   writeback FIFO entries (power of 2, >=2)
// - PTR_W   2   log2(DEPTH)
// - DATA_W  16  register width
// - ADDR_W  4   register index width
// PORTS
// - clk         in   1       system clock, rising edge
// - rst         in   1       asynchronous, active-low reset
// - wb_valid    in   1       writeback request valid
// - wb_ready    out  1       FIFO can accept a request
// - wb_addr     in   ADDR_W  destination register
// - wb_data     in   DATA_W  value to write
// - rd_sel      in   8       read selects, [7:4]=port A, [3:0]=port B
// - fwd_hit_a   out  1       pending write matches rd_sel[7:4]
// - fwd_data_a  out  DATA_W  newest pending value for port A
// - fwd_hit_b   out  1       pending write matches rd_sel[3:0]
// - fwd_data_b  out  DATA_W  newest pending value for port B
// - rf_write    out  1       register group write strobe
// - rf_address  out  ADDR_W  register group write address
// - rf_data_in  out  DATA_W  register group write data
// - busy        out  1       FIFO not empty or state != IDLE
// BEHAVIOUR
// - Reset (rst=0, async): FIFO empty, state=IDLE, rf_write=0, rf_address=0,
//   rf_data_in=0. All fwd_* outputs read 0.
// - Accept: a transfer occurs when wb_valid & wb_ready at a clk edge.
//   wb_ready = !full and does not depend on wb_valid.
// - R0 drop: a transfer with wb_addr==0 is accepted but not enqueued.
// - Full: no bypass of a same-cycle pop. If the FIFO is full during HOLD,
//   wb_ready stays 0 that cycle. Requests are never lost or overwritten.
// - FSM, all outputs registered:
//   - IDLE: if not empty, go to SETUP and load rf_address/rf_data_in from head.
//   - SETUP: rf_write=0, go to STROBE.
//   - STROBE: rf_write=1 for exactly one cycle, go to HOLD.
//   - HOLD: rf_write=0, address/data held. Pop head at the exit edge. If entries
//     remain, including one enqueued that same edge, go to SETUP and load the
//     new head. Otherwise go to IDLE.
// - Latency: request accepted at edge E0 -> rf_address valid after E1 ->
//   rf_write high after E2 -> low after E3 -> popped at E4.
// - Throughput: back-to-back writes take 3 cycles each.
// - rf_address and rf_data_in are stable from SETUP through HOLD and never
//   change while rf_write=1.
// - Forwarding (combinational):
//   - Searches all valid FIFO entries, including the head currently being
//     written. The youngest match wins.
//   - Select 0 never hits.
//   - A request being accepted in the current cycle is not forwarded.
//   - On a miss, fwd_data_* = 0.
// - Ordering: writes commit in acceptance order. Two writes to the same register
//   leave the later value.
// - Reset mid-operation flushes the FIFO. A write whose STROBE has already
//   started is treated as committed. A truncated strobe is acceptable.
// - Pointers wrap modulo DEPTH. count is kept in PTR_W+1 bits.
// TESTING
// - Single write {R3,0x1234} at E0: rf_address=3 and rf_data_in=0x1234 after E1,
//   rf_write=1 only for the cycle after E2, busy=0 after E4.
// - Write {R0,0xFFFF}: accepted (wb_ready=1), rf_write never pulses, busy stays 0.
// - Hold wb_valid high with 6 distinct writes: wb_ready drops after 4 are
//   queued, all 6 commit in order at 3-cycle spacing, none lost.
// - Queue {R5,0x0001} then {R5,0x0002} with rd_sel=0x5_2:
//   fwd_hit_a=1, fwd_data_a=0x0002, fwd_hit_b=0.
//   After both commit, fwd_hit_a=0.
// - Full FIFO with state=HOLD and wb_valid=1: wb_ready=0 that cycle.
//   The request is accepted the next cycle and commits last.
// - Assert rst=0 during STROBE with 3 entries queued: rf_write=0 and busy=0
//   immediately, no further strobes after release.

Source files
------------

// File: rtl/reg_writeback_port_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg_writeback_port_if
//  Purpose  : Bundles the pipeline-side writeback handshake, the forwarding
//             lookup and the register-group write bus of reg_writeback_port.
//  Ports    : master = pipeline / register-group side
//             slave  = reg_writeback_port side
//  Revision : 1.0 - initial release
// ============================================================================
interface reg_writeback_port_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);
  // Writeback request handshake
  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  // Forwarding lookup: [7:4] selects port A, [3:0] selects port B
  logic [7:0]        rd_sel;
  logic              fwd_hit_a;
  logic [DATA_W-1:0] fwd_data_a;
  logic              fwd_hit_b;
  logic [DATA_W-1:0] fwd_data_b;
  // Register-group write bus
  logic              rf_write;
  logic [ADDR_W-1:0] rf_address;
  logic [DATA_W-1:0] rf_data_in;
  // Status
  logic              busy;

  modport master (
    output wb_valid, wb_addr, wb_data, rd_sel,
    input  wb_ready, fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
    input  rf_write, rf_address, rf_data_in, busy
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, rd_sel,
    output wb_ready, fwd_hit_a, fwd_data_a, fwd_hit_b, fwd_data_b,
    output rf_write, rf_address, rf_data_in, busy
  );
endinterface
`default_nettype wire

// File: rtl/reg_writeback_port.sv
`default_nettype none
// ============================================================================
//  Module   : reg_writeback_port
//  Purpose  : Write-side driver for the 16x16 register group. Buffers
//             writeback requests in a small FIFO, replays each one as a
//             SETUP / STROBE / HOLD sequence on the group's write bus and
//             forwards not-yet-committed values to the two decode read ports.
//  Ports    : clk  - system clock, rising edge
//             rst  - asynchronous, active-low reset
//             bus  - reg_writeback_port_if.slave (wb_*, rd_sel, fwd_*, rf_*,
//                    busy)
//  Revision : 1.0 - initial release
// ============================================================================
module reg_writeback_port #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  reg_writeback_port_if.slave  bus
);

  localparam logic [PTR_W:0]   c_full_count = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   c_one_count  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] c_ptr_one    = PTR_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // FIFO storage and bookkeeping
  logic [ADDR_W-1:0] r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;

  // FSM and registered write bus
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_rf_write;
  logic              w_rf_write_nxt;
  logic [ADDR_W-1:0] r_rf_address;
  logic [ADDR_W-1:0] w_rf_address_nxt;
  logic [DATA_W-1:0] r_rf_data_in;
  logic [DATA_W-1:0] w_rf_data_in_nxt;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_next_head;

  // Ready depends only on occupancy; a pop in the same cycle is not used to
  // make room, which keeps wb_ready free of any path from the FSM.
  assign w_ready     = (r_count != c_full_count);
  // Writes to R0 are accepted and silently discarded.
  assign w_push      = bus.wb_valid & w_ready & (bus.wb_addr != '0);
  // The head leaves the FIFO on the edge that ends HOLD.
  assign w_pop       = (r_state == S_HOLD);
  assign w_next_head = r_rd_ptr + c_ptr_one;

  // --------------------------------------------------------------------------
  // FIFO pointers and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= w_next_head;
      end
      r_count <= r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  // Storage carries no reset: only entries below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.wb_addr;
      r_fifo_data[r_wr_ptr] <= bus.wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // Write sequencer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rf_write   <= 1'b0;
      r_rf_address <= '0;
      r_rf_data_in <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rf_write   <= w_rf_write_nxt;
      r_rf_address <= w_rf_address_nxt;
      r_rf_data_in <= w_rf_data_in_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_rf_write_nxt   = 1'b0;
    w_rf_address_nxt = r_rf_address;
    w_rf_data_in_nxt = r_rf_data_in;

    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          w_state_nxt      = S_SETUP;
          w_rf_address_nxt = r_fifo_addr[r_rd_ptr];
          w_rf_data_in_nxt = r_fifo_data[r_rd_ptr];
        end
      end
      S_SETUP: begin
        w_state_nxt    = S_STROBE;
        w_rf_write_nxt = 1'b1;
      end
      S_STROBE: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        // Chain straight into the next entry. When the head is the only
        // stored entry, a request pushed on this same edge is not in the
        // array yet, so it is taken from the request bus directly.
        if (r_count > c_one_count) begin
          w_state_nxt      = S_SETUP;
          w_rf_address_nxt = r_fifo_addr[w_next_head];
          w_rf_data_in_nxt = r_fifo_data[w_next_head];
        end else if (w_push) begin
          w_state_nxt      = S_SETUP;
          w_rf_address_nxt = bus.wb_addr;
          w_rf_data_in_nxt = bus.wb_data;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Forwarding: scan oldest to youngest so the youngest match overwrites any
  // older one. The head stays visible until it is popped at the end of HOLD.
  // --------------------------------------------------------------------------
  logic              w_hit_a;
  logic              w_hit_b;
  logic [DATA_W-1:0] w_data_a;
  logic [DATA_W-1:0] w_data_b;
  logic [3:0]        w_sel_a;
  logic [3:0]        w_sel_b;

  assign w_sel_a = bus.rd_sel[7:4];
  assign w_sel_b = bus.rd_sel[3:0];

  always_comb begin
    w_hit_a  = 1'b0;
    w_hit_b  = 1'b0;
    w_data_a = '0;
    w_data_b = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((PTR_W+1)'(i) < r_count) begin
        if ((w_sel_a != 4'd0) &&
            (r_fifo_addr[r_rd_ptr + PTR_W'(i)] == ADDR_W'(w_sel_a))) begin
          w_hit_a  = 1'b1;
          w_data_a = r_fifo_data[r_rd_ptr + PTR_W'(i)];
        end
        if ((w_sel_b != 4'd0) &&
            (r_fifo_addr[r_rd_ptr + PTR_W'(i)] == ADDR_W'(w_sel_b))) begin
          w_hit_b  = 1'b1;
          w_data_b = r_fifo_data[r_rd_ptr + PTR_W'(i)];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.wb_ready   = w_ready;
  assign bus.fwd_hit_a  = w_hit_a;
  assign bus.fwd_data_a = w_data_a;
  assign bus.fwd_hit_b  = w_hit_b;
  assign bus.fwd_data_b = w_data_b;
  assign bus.rf_write   = r_rf_write;
  assign bus.rf_address = r_rf_address;
  assign bus.rf_data_in = r_rf_data_in;
  assign bus.busy       = (r_count != '0) || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_writeback_port
//  Purpose  : Directed self-checking bench for reg_writeback_port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_reg_writeback_port;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  reg_writeback_port_if #(.DATA_W(16), .ADDR_W(4)) bus ();

  reg_writeback_port #(
    .DEPTH (4),
    .PTR_W (2),
    .DATA_W(16),
    .ADDR_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 50 && bus.busy === 1'b1; k++) step();
    chk(tag, bus.busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic       seen;
    int         acc;
    int         commits;
    int         last_cyc;
    int         first_low_acc;
    int         first_low_cyc;
    logic       ready_after_low;
    logic       rdy;

    bus.wb_valid = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    bus.rd_sel   = '0;

    // ---------------- reset state ----------------
    step();
    step();
    chk("rst_rf_write",   bus.rf_write,   1'b0);
    chk("rst_rf_address", bus.rf_address, 4'h0);
    chk("rst_rf_data_in", bus.rf_data_in, 16'h0000);
    chk("rst_busy",       bus.busy,       1'b0);
    chk("rst_wb_ready",   bus.wb_ready,   1'b1);
    chk("rst_fwd_hit_a",  bus.fwd_hit_a,  1'b0);
    chk("rst_fwd_data_a", bus.fwd_data_a, 16'h0000);
    rst = 1'b1;
    step();

    // ---------------- single write R3 <= 0x1234 ----------------
    bus.rd_sel   = 8'h30;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd3;
    bus.wb_data  = 16'h1234;
    chk("t1_fwd_same_cycle", bus.fwd_hit_a, 1'b0);
    step();                                   // E0: accepted
    bus.wb_valid = 1'b0;
    chk("t1_busy_e0",     bus.busy,       1'b1);
    chk("t1_fwd_hit_a",   bus.fwd_hit_a,  1'b1);
    chk("t1_fwd_data_a",  bus.fwd_data_a, 16'h1234);
    chk("t1_fwd_hit_b",   bus.fwd_hit_b,  1'b0);
    chk("t1_addr_e0",     bus.rf_address, 4'h0);
    step();                                   // E1: SETUP
    chk("t1_addr_e1",     bus.rf_address, 4'h3);
    chk("t1_data_e1",     bus.rf_data_in, 16'h1234);
    chk("t1_write_e1",    bus.rf_write,   1'b0);
    step();                                   // E2: STROBE
    chk("t1_write_e2",    bus.rf_write,   1'b1);
    step();                                   // E3: HOLD
    chk("t1_write_e3",    bus.rf_write,   1'b0);
    chk("t1_addr_e3",     bus.rf_address, 4'h3);
    step();                                   // E4: popped
    chk("t1_busy_e4",     bus.busy,       1'b0);
    chk("t1_fwd_after",   bus.fwd_hit_a,  1'b0);

    // ---------------- R0 write is dropped ----------------
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd0;
    bus.wb_data  = 16'hFFFF;
    chk("t2_ready", bus.wb_ready, 1'b1);
    step();
    bus.wb_valid = 1'b0;
    seen = bus.rf_write | bus.busy;
    for (int k = 0; k < 5; k++) begin
      step();
      seen = seen | bus.rf_write | bus.busy;
    end
    chk("t2_no_activity", seen, 1'b0);

    // ---------------- six back-to-back writes ----------------
    acc             = 0;
    commits         = 0;
    last_cyc        = -1;
    first_low_acc   = -1;
    first_low_cyc   = -1;
    ready_after_low = 1'b0;
    bus.wb_valid    = 1'b1;
    bus.wb_addr     = 4'd1;
    bus.wb_data     = 16'hA001;
    for (int cyc = 0; cyc < 60 && commits < 6; cyc++) begin
      rdy = bus.wb_ready;
      if (rdy === 1'b0 && first_low_acc < 0) begin
        first_low_acc = acc;
        first_low_cyc = cyc;
      end
      if (first_low_cyc >= 0 && cyc == first_low_cyc + 1) ready_after_low = rdy;
      step();
      if (rdy === 1'b1 && bus.wb_valid === 1'b1) begin
        acc++;
        if (acc == 6) begin
          bus.wb_valid = 1'b0;
        end else begin
          bus.wb_addr = 4'(acc + 1);
          bus.wb_data = 16'hA000 + 16'(acc + 1);
        end
      end
      if (bus.rf_write === 1'b1) begin
        chk($sformatf("t3_addr_%0d", commits), bus.rf_address, 32'(commits + 1));
        chk($sformatf("t3_data_%0d", commits), bus.rf_data_in, 32'h0000A000 + 32'(commits + 1));
        if (commits > 0) chk($sformatf("t3_gap_%0d", commits), 32'(cyc - last_cyc), 32'd3);
        last_cyc = cyc;
        commits++;
      end
    end
    bus.wb_valid = 1'b0;
    chk("t3_commits",        32'(commits),       32'd6);
    chk("t3_full_after",     32'(first_low_acc), 32'd4);
    chk("t3_ready_after_hold", ready_after_low,  1'b1);
    wait_idle("t3_idle");

    // ---------------- forwarding, youngest wins ----------------
    bus.rd_sel   = 8'h52;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd5;
    bus.wb_data  = 16'h0001;
    chk("t4_no_fwd_accepting", bus.fwd_hit_a, 1'b0);
    step();
    bus.wb_data  = 16'h0002;
    step();
    bus.wb_valid = 1'b0;
    chk("t4_hit_a",  bus.fwd_hit_a,  1'b1);
    chk("t4_data_a", bus.fwd_data_a, 16'h0002);
    chk("t4_hit_b",  bus.fwd_hit_b,  1'b0);
    chk("t4_data_b", bus.fwd_data_b, 16'h0000);
    wait_idle("t4_idle");
    chk("t4_hit_a_after",  bus.fwd_hit_a,  1'b0);
    chk("t4_data_a_after", bus.fwd_data_a, 16'h0000);

    // ---------------- reset during STROBE ----------------
    bus.rd_sel   = 8'h00;
    bus.wb_valid = 1'b1;
    bus.wb_addr  = 4'd7;
    bus.wb_data  = 16'h0707;
    step();                                   // E0
    bus.wb_addr  = 4'd8;
    bus.wb_data  = 16'h0808;
    step();                                   // E1: SETUP
    bus.wb_addr  = 4'd9;
    bus.wb_data  = 16'h0909;
    step();                                   // E2: STROBE, 3 queued
    bus.wb_valid = 1'b0;
    chk("t5_strobe", bus.rf_write, 1'b1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_write", bus.rf_write,   1'b0);
    chk("t5_rst_busy",  bus.busy,       1'b0);
    chk("t5_rst_addr",  bus.rf_address, 4'h0);
    rst = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      seen = seen | bus.rf_write | bus.busy;
    end
    chk("t5_no_strobe_after", seen, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
